// File: rtl/wb_regfile.sv
// Writeback-stage register file: 32 GPRs plus HI/LO, committed on the rising edge,
// with two bypassed combinational GPR read ports and a bypassed HI/LO read port.
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              whilo,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // NOTE: the whole array is cleared on reset because software relies on every
  // GPR starting at 0; this keeps it out of block RAM, which is acceptable at 32 entries.
  // NOTE: non-blocking assignments so every reader in this edge sees pre-edge state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (we && waddr != '0) regs[waddr] <= wdata;
      if (whilo) begin
        hi_q <= hi_i;
        lo_q <= lo_i;
      end
    end
  end

  // NOTE: each output gets a default first so no path through the priority chain
  // can leave it unassigned and infer a latch.
  always_comb begin
    rdata1 = '0;
    if (rst || raddr1 == '0)              rdata1 = '0;
    else if (re1 && we && raddr1 == waddr) rdata1 = wdata;
    else if (re1)                          rdata1 = regs[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (rst || raddr2 == '0)              rdata2 = '0;
    else if (re2 && we && raddr2 == waddr) rdata2 = wdata;
    else if (re2)                          rdata2 = regs[raddr2];
  end

  // HI/LO bypass lets a mult/div result in writeback feed mfhi/mflo in the same cycle.
  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (rst) begin
      hi_o = '0;
      lo_o = '0;
    end else if (whilo) begin
      hi_o = hi_i;
      lo_o = lo_i;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: per-cycle vector table with hand-derived
// expectations pushed to a scoreboard queue and compared against the combinational outputs.
module tb_wb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi_i;
    logic [DATA_W-1:0] lo_i;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] exp_rdata1;
    logic [DATA_W-1:0] exp_rdata2;
    logic [DATA_W-1:0] exp_hi;
    logic [DATA_W-1:0] exp_lo;
  } vec_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              whilo;
  logic [DATA_W-1:0] hi_i;
  logic [DATA_W-1:0] lo_i;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  vec_t vecs[15];

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .we(we), .waddr(waddr), .wdata(wdata),
    .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DATA_W-1:0] actual,
                       input logic [DATA_W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic rst_v, input logic we_v, input int wa, input logic [DATA_W-1:0] wd,
    input logic whilo_v, input logic [DATA_W-1:0] hi_v, input logic [DATA_W-1:0] lo_v,
    input logic re1_v, input int ra1, input logic re2_v, input int ra2,
    input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2,
    input logic [DATA_W-1:0] ehi, input logic [DATA_W-1:0] elo);
    vec_t v;
    v.rst = rst_v; v.we = we_v; v.waddr = ADDR_W'(wa); v.wdata = wd;
    v.whilo = whilo_v; v.hi_i = hi_v; v.lo_i = lo_v;
    v.re1 = re1_v; v.raddr1 = ADDR_W'(ra1); v.re2 = re2_v; v.raddr2 = ADDR_W'(ra2);
    v.exp_rdata1 = e1; v.exp_rdata2 = e2; v.exp_hi = ehi; v.exp_lo = elo;
    return v;
  endfunction

  // Drive one cycle of inputs, push its expectation, sample mid-cycle, then advance past the edge.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    rst = v.rst; we = v.we; waddr = v.waddr; wdata = v.wdata;
    whilo = v.whilo; hi_i = v.hi_i; lo_i = v.lo_i;
    re1 = v.re1; raddr1 = v.raddr1; re2 = v.re2; raddr2 = v.raddr2;
    sb_q.push_back({v.exp_rdata1, v.exp_rdata2, v.exp_hi, v.exp_lo});
    #2;
    e = sb_q.pop_front();
    check({tag, ".rdata1"}, rdata1, e.rdata1);
    check({tag, ".rdata2"}, rdata2, e.rdata2);
    check({tag, ".hi_o"},   hi_o,   e.hi);
    check({tag, ".lo_o"},   lo_o,   e.lo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst we wa wdata         whilo hi            lo            re1 ra1 re2 ra2  rdata1        rdata2        hi            lo
    vecs[0]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 32'h0,        32'h0,        1, 5,  0, 0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0);
    vecs[1]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 5,  0, 0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0);
    vecs[2]  = mk(0, 1, 0, 32'h12345678, 0, 32'h0,        32'h0,        1, 5,  1, 0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0);
    vecs[3]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0,  1, 0, 32'h0,        32'h0,        32'h0,        32'h0);
    vecs[4]  = mk(0, 0, 0, 32'h0,        1, 32'h1,        32'hFFFFFFFE, 0, 0,  0, 0, 32'h0,        32'h0,        32'h1,        32'hFFFFFFFE);
    vecs[5]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 5,  0, 0, 32'hDEADBEEF, 32'h0,        32'h1,        32'hFFFFFFFE);
    vecs[6]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 5,  0, 5, 32'h0,        32'h0,        32'h1,        32'hFFFFFFFE);
    vecs[7]  = mk(0, 1, 7, 32'hA5A5A5A5, 0, 32'h0,        32'h0,        1, 7,  1, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1,        32'hFFFFFFFE);
    vecs[8]  = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 7,  1, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1,        32'hFFFFFFFE);
    vecs[9]  = mk(0, 1, 9, 32'h0BADF00D, 1, 32'h11,       32'h22,       1, 9,  1, 5, 32'h0BADF00D, 32'hDEADBEEF, 32'h11,       32'h22);
    vecs[10] = mk(1, 1, 3, 32'h55,       1, 32'h77,       32'h0,        1, 5,  1, 3, 32'h0,        32'h0,        32'h0,        32'h0);
    vecs[11] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 5,  1, 3, 32'h0,        32'h0,        32'h0,        32'h0);
    vecs[12] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 9,  1, 7, 32'h0,        32'h0,        32'h0,        32'h0);
    vecs[13] = mk(0, 1, 3, 32'h55,       0, 32'h0,        32'h0,        1, 3,  0, 3, 32'h55,       32'h0,        32'h0,        32'h0);
    vecs[14] = mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 1,  1, 3, 32'h0,        32'h55,       32'h0,        32'h0);

    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; whilo = 1'b0; hi_i = '0; lo_i = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    repeat (2) @(posedge clk);
    #1;

    // Post-reset sweep: every address on both ports reads zero.
    for (int i = 0; i < 32; i++)
      step(mk(0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1, i, 1, 31 - i,
              32'h0, 32'h0, 32'h0, 32'h0), $sformatf("sweep[%0d]", i));

    for (int i = 0; i < 15; i++)
      step(vecs[i], $sformatf("vec[%0d]", i));

    // Two back-to-back writes to the same register: bypass shows the newer data,
    // storage keeps the last one.
    step(mk(0, 1, 12, 32'h1111_1111, 0, 32'h0, 32'h0, 1, 12, 0, 0,
            32'h1111_1111, 32'h0, 32'h0, 32'h0), "ww0");
    step(mk(0, 1, 12, 32'h2222_2222, 0, 32'h0, 32'h0, 1, 12, 1, 12,
            32'h2222_2222, 32'h2222_2222, 32'h0, 32'h0), "ww1");
    step(mk(0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 12, 1, 12,
            32'h0, 32'h2222_2222, 32'h0, 32'h0), "ww2");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer that sits directly downstream of the MEM/WB pipeline register.
- Holds the 32x32 general-purpose register file and the HI/LO special registers.
- Commits the writeback bundle (GPR write plus HI/LO write) on the clock edge.
- Serves two combinational GPR read ports and a HI/LO read port to the decode and execute stages, with same-cycle write-to-read bypass so that no extra forwarding path is needed for a writeback-stage producer.

Parameters:
- DATA_W, 32, width of GPR, HI and LO registers
- ADDR_W, 5, GPR address width
- NUM_REGS, 32, number of GPR entries (2**ADDR_W)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- we  input  1  GPR write enable (from wb_wreg)
- waddr  input  ADDR_W  GPR write address (from wb_wd)
- wdata  input  DATA_W  GPR write data (from wb_wdata)
- whilo  input  1  HI/LO write enable (from wb_whilo)
- hi_i  input  DATA_W  HI write data (from wb_hi)
- lo_i  input  DATA_W  LO write data (from wb_lo)
- re1  input  1  read port 1 enable
- raddr1  input  ADDR_W  read port 1 address
- rdata1  output  DATA_W  read port 1 data (combinational)
- re2  input  1  read port 2 enable
- raddr2  input  ADDR_W  read port 2 address
- rdata2  output  DATA_W  read port 2 data (combinational)
- hi_o  output  DATA_W  current HI value (combinational, bypassed)
- lo_o  output  DATA_W  current LO value (combinational, bypassed)

Behaviour:
- Reset is synchronous, active-high; clock is clk.
  - On a rising edge with rst=1, all NUM_REGS GPR entries, HI and LO clear to 0.
  - Any we/whilo asserted in that cycle is ignored.
- While rst=1, rdata1, rdata2, hi_o and lo_o are all forced to 0 combinationally, regardless of other inputs.
- GPR write: on a rising edge with rst=0, we=1 and waddr!=0, reg[waddr] <= wdata.
  - Writes to address 0 are discarded; reg[0] always reads 0.
- HI/LO write: on a rising edge with rst=0 and whilo=1, HI <= hi_i and LO <= lo_i together. Partial HI-only or LO-only writes do not exist.
- GPR write and HI/LO write are independent. Both may occur in the same cycle.
- Read port N (N=1,2) uses this priority order:
  1. rst=1 -> 0
  2. raddrN==0 -> 0, even when we=1 with waddr==0
  3. reN=1, we=1, raddrN==waddr -> wdata (bypass; the write commits at the next edge)
  4. reN=1 -> reg[raddrN]
  5. reN=0 -> 0
- Both read ports may address the same register, and both may bypass simultaneously.
- HI/LO read:
  - rst=1 -> 0.
  - whilo=1 -> hi_o=hi_i, lo_o=lo_i (bypass).
  - Otherwise HI and LO hold their stored values.
- Latency:
  - Write-to-architectural-state: 1 edge.
  - Write-to-read visibility: 0 cycles, via bypass.
- Reads never modify state. No stall input: the upstream MEM/WB register inserts bubbles (we=0, whilo=0), and a bubble leaves all state unchanged.
- No X propagation: every output is defined for every input combination listed above.
- Reset mid-stream: a write presented in the same cycle as rst=1 is lost. Writes after rst deasserts proceed normally from the cleared state.

Test Plan:
- Reset, then rst=0. Read all 32 addresses on both ports with re1=re2=1 -> every read returns 0x00000000; hi_o=lo_o=0.
- Write we=1, waddr=5, wdata=0xDEADBEEF with re1=1, raddr1=5 in the same cycle -> rdata1=0xDEADBEEF before the edge (bypass). After the edge with we=0 -> rdata1 still 0xDEADBEEF (stored).
- Write we=1, waddr=0, wdata=0x12345678 with re2=1, raddr2=0 -> rdata2=0 in that cycle and all later cycles.
- whilo=1, hi_i=0x0000_0001, lo_i=0xFFFF_FFFE -> hi_o/lo_o show those values in the same cycle and remain after whilo=0. Then rst=1 for one edge -> hi_o=lo_o=0 and reg[5] reads 0.
- re1=0, raddr1=5 (reg[5]=0xDEADBEEF) -> rdata1=0. Concurrent we=1, waddr=7, wdata=0xA5A5A5A5 with re2=1, raddr2=7 and re1=1, raddr1=7 -> both ports return 0xA5A5A5A5.
- rst=1 with we=1, waddr=3, wdata=0x55 and whilo=1, hi_i=0x77 -> after the edge with rst=0, reg[3]=0 and HI=0; the write is lost.
